// File: rtl/m9k_burst_master.sv
`default_nettype none
// ============================================================================
//  Module      : m9k_burst_master
//  Description : Burst initiator for one single-port M9K bank. Converts a
//                (base, length, direction) command into sequential word
//                writes fed from a valid/ready stream, or sequential word
//                reads (1-cycle registered bank read) delivered on a
//                valid/ready stream through a 2-entry skid buffer.
//  Options     : M9K_BURST_BOUNDS_EN - adds the err output and rejects bursts
//                that would run past the top of the bank.
//  Revision    : 1.0 - initial release
// ============================================================================
module m9k_burst_master #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_base,
  input  logic [LEN_W-1:0]  req_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              done,
  output logic              mem_w_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_store,
  input  logic [DATA_W-1:0] mem_data_load
`ifdef M9K_BURST_BOUNDS_EN
  ,
  output logic              err
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WR    = 2'd1,
    ST_RD    = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [LEN_W-1:0]  remaining_q, remaining_d;
  logic [DATA_W-1:0] buf0_q, buf0_d;   // buffer head
  logic [DATA_W-1:0] buf1_q, buf1_d;   // buffer second entry
  logic [1:0]        occ_q, occ_d;
  logic              inflight_q, inflight_d;
  logic              done_q, done_d;

  logic              pop;
  logic              push;
  logic [2:0]        slots_used;       // words held or in flight after this cycle's pop
  logic [1:0]        occ_after_pop;

`ifdef M9K_BURST_BOUNDS_EN
  localparam logic [ADDR_W+LEN_W:0] BANK_WORDS = {{LEN_W{1'b0}}, 1'b1, {ADDR_W{1'b0}}};
  logic                  err_q, err_d;
  logic [ADDR_W+LEN_W:0] end_addr;
  logic                  out_of_bounds;

  // One-past-the-end address of the requested burst, wide enough never to wrap
  always_comb begin
    end_addr      = {{(LEN_W+1){1'b0}}, req_base} + {{(ADDR_W+1){1'b0}}, req_len};
    out_of_bounds = (end_addr > BANK_WORDS);
  end
`endif

  // Burst sequencing: next state, address/length bookkeeping and bank drive
  always_comb begin
    state_d        = state_q;
    cur_addr_d     = cur_addr_q;
    remaining_d    = remaining_q;
    inflight_d     = 1'b0;
    done_d         = 1'b0;
`ifdef M9K_BURST_BOUNDS_EN
    err_d          = 1'b0;
`endif
    req_ready      = 1'b0;
    wr_ready       = 1'b0;
    mem_w_en       = 1'b0;
    mem_addr       = '0;
    mem_data_store = '0;
    pop            = (occ_q != 2'd0) && rd_ready;
    push           = inflight_q;
    slots_used     = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};

    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          cur_addr_d  = req_base;
          remaining_d = req_len;
          if (req_len == '0) begin
            done_d = 1'b1;
          end
`ifdef M9K_BURST_BOUNDS_EN
          else if (out_of_bounds) begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end
`endif
          else if (req_write) begin
            state_d = ST_WR;
          end else begin
            state_d = ST_RD;
          end
        end
      end

      ST_WR: begin
        wr_ready = 1'b1;
        if (wr_valid) begin
          mem_w_en       = 1'b1;
          mem_addr       = cur_addr_q;
          mem_data_store = wr_data;
          cur_addr_d     = cur_addr_q + ADDR_W'(1);
          remaining_d    = remaining_q - LEN_W'(1);
          if (remaining_q == LEN_W'(1)) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end

      ST_RD: begin
        // Only issue when the word coming back is guaranteed a buffer slot
        if ((remaining_q != '0) && (slots_used < 3'd2)) begin
          mem_addr    = cur_addr_q;
          inflight_d  = 1'b1;
          cur_addr_d  = cur_addr_q + ADDR_W'(1);
          remaining_d = remaining_q - LEN_W'(1);
          if (remaining_q == LEN_W'(1)) begin
            state_d = ST_DRAIN;
          end
        end
      end

      ST_DRAIN: begin
        if ((occ_q == 2'd0) && !inflight_q) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Hold every handshake and bank output quiet while reset is asserted
    if (rst) begin
      req_ready      = 1'b0;
      wr_ready       = 1'b0;
      mem_w_en       = 1'b0;
      mem_addr       = '0;
      mem_data_store = '0;
    end
  end

  // Read buffer: pop shifts the head out, returning word lands at the new tail
  always_comb begin
    buf0_d        = buf0_q;
    buf1_d        = buf1_q;
    occ_after_pop = occ_q - {1'b0, pop};
    if (pop) begin
      buf0_d = buf1_q;
    end
    if (push) begin
      if (occ_after_pop == 2'd0) begin
        buf0_d = mem_data_load;
      end else begin
        buf1_d = mem_data_load;
      end
    end
    occ_d = occ_after_pop + {1'b0, push};
  end

  // Read-side and completion outputs, forced to zero during reset
  always_comb begin
    rd_valid = (occ_q != 2'd0) && !rst;
    rd_data  = rd_valid ? buf0_q : '0;
    done     = done_q && !rst;
`ifdef M9K_BURST_BOUNDS_EN
    err      = err_q && !rst;
`endif
  end

  // State and datapath registers; reset abandons any burst in progress
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      buf0_q      <= '0;
      buf1_q      <= '0;
      occ_q       <= 2'd0;
      inflight_q  <= 1'b0;
      done_q      <= 1'b0;
`ifdef M9K_BURST_BOUNDS_EN
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      buf0_q      <= buf0_d;
      buf1_q      <= buf1_d;
      occ_q       <= occ_d;
      inflight_q  <= inflight_d;
      done_q      <= done_d;
`ifdef M9K_BURST_BOUNDS_EN
      err_q       <= err_d;
`endif
    end
  end

endmodule
`default_nettype wire

// File: doc/m9k_burst_master.md
Name: m9k_burst_master

Overview:
- Initiator side of the single-port M9K word interface (w_en / addr / data_store / data_load, 1-cycle registered read).
- Turns one command (base, length, direction) into a burst of sequential word writes or reads.
- Writes are fed from a valid/ready stream; read data leaves on a valid/ready stream with backpressure.
- Sits between tensor load/store sequencing logic and one M9K bank.

Parameters:
ADDR_W, 15, word address width into the bank
DATA_W, 32, word width
LEN_W, 16, burst length field width, in words

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
req_valid  input  1  command valid
req_ready  output  1  command accepted when valid&ready
req_write  input  1  1 = write burst, 0 = read burst
req_base  input  ADDR_W  first word address
req_len  input  LEN_W  words in burst
wr_valid  input  1  write data valid
wr_ready  output  1  write data accepted
wr_data  input  DATA_W  write word
rd_valid  output  1  read word valid
rd_ready  input  1  consumer ready
rd_data  output  DATA_W  read word
done  output  1  one-cycle pulse at burst completion
mem_w_en  output  1  to bank w_en
mem_addr  output  ADDR_W  to bank addr
mem_data_store  output  DATA_W  to bank data_store
mem_data_load  input  DATA_W  from bank data_load

Behaviour:
- Interface: one clock (clk); reset rst is synchronous, active-high.
- States: IDLE, WR, RD, DRAIN.
- Registers: cur_addr (ADDR_W), remaining (LEN_W), 2-entry read buffer with occupancy occ, 1-bit inflight flag.
- Reset: state IDLE, occ=0, inflight=0, cur_addr=0, remaining=0. While rst is high: req_ready=0, wr_ready=0, rd_valid=0, done=0, mem_w_en=0, mem_addr=0, mem_data_store=0, rd_data=0.
- IDLE:
  - req_ready=1.
  - On accept: cur_addr<=req_base, remaining<=req_len.
  - req_len==0 -> stay IDLE, done pulses the next cycle, no bank access.
  - Otherwise go to WR (req_write=1) or RD (req_write=0).
- WR:
  - wr_ready=1.
  - mem_w_en = wr_valid; mem_addr = cur_addr; mem_data_store = wr_data (combinational, zero added latency). The bank writes on the same edge.
  - Each transfer: cur_addr+1, remaining-1.
  - Last transfer -> IDLE, done pulses the following cycle.
  - wr_valid low = stall. No writes occur outside WR.
- RD, issue:
  - mem_w_en=0 at all times.
  - Issue a read when occ + inflight - pop < 2, where pop = rd_valid & rd_ready.
  - An issue drives mem_addr=cur_addr, sets inflight, advances cur_addr, and decrements remaining.
- RD, capture:
  - The cycle after an issue, mem_data_load is written into the buffer tail and inflight clears.
  - rd_valid = (occ!=0); rd_data = buffer head.
  - Latency: rd_valid first rises 2 cycles after the first issue cycle, i.e. 3 cycles after command acceptance.
  - Throughput: 1 word/cycle while rd_ready is held high.
- RD, backpressure and drain:
  - rd_ready low: at most 2 words are outstanding and none is lost. An in-flight word always has a free slot.
  - When the final issue has occurred -> DRAIN.
  - DRAIN waits for occ==0 and inflight==0, then -> IDLE, done pulses the following cycle.
- Boundary conditions:
  - Address arithmetic is modulo 2^ADDR_W: 0x7FFF+1 = 0x0000.
  - req_len > 2^ADDR_W revisits addresses.
  - mem_addr = 0 when no access is driven.
  - A new command is not accepted until the state is back in IDLE; done and the next accept may coincide.
- Reset mid-burst: the burst is abandoned, the buffer is flushed, any in-flight word is discarded, no done pulse, outputs go to their reset values.

Optional Feature:
M9K_BURST_BOUNDS_EN
- Defined: adds output err (1 bit, reset 0).
- A command with req_base + req_len > 2^ADDR_W (computed at ADDR_W+LEN_W+1 bits) is accepted, but no bank access occurs.
- State stays IDLE; done and err pulse together the next cycle.
- Undefined: no err port; addresses wrap as above.

Test Plan:
- Write req base=0x0010 len=4, wr_data 0xA0..0xA3 with wr_valid held high -> mem_w_en high 4 consecutive cycles at addr 0x10..0x13; done one cycle after the last write.
- Read req base=0x0010 len=4, rd_ready=1 -> rd_valid 4 consecutive cycles with 0xA0..0xA3; first rd_valid 3 cycles after accept; done after the last pop.
- Same read with rd_ready toggled 1,0,0,1,0,1... -> data order preserved, no drops or duplicates, occ never exceeds 2.
- req_len=0, read and write -> no mem_w_en, no reads; done one cycle after accept; req_ready high again immediately.
- Write base=0x7FFE len=4 -> addresses 0x7FFE, 0x7FFF, 0x0000, 0x0001; with M9K_BURST_BOUNDS_EN: no writes; err and done pulse together.
- rst asserted for 1 cycle after 2 of 8 read words delivered -> rd_valid=0 next cycle, no done; a fresh len=1 read then returns the correct word.
